// File: rtl/blink_pkg.sv
// Shared constants for the blink RTC: I/O port map and status bit positions.
package blink_pkg;

    localparam logic [7:0] RTC_TACK = 8'hB4;
    localparam logic [7:0] RTC_TMK  = 8'hB5;
    localparam logic [7:0] RTC_TSTA = 8'hB5;
    localparam logic [7:0] RTC_TIM0 = 8'hD0;
    localparam logic [7:0] RTC_TIM1 = 8'hD1;
    localparam logic [7:0] RTC_TIM2 = 8'hD2;
    localparam logic [7:0] RTC_TIM3 = 8'hD3;
    localparam logic [7:0] RTC_TIM4 = 8'hD4;

    localparam int TSTA_TICK = 0;
    localparam int TSTA_SEC  = 1;
    localparam int TSTA_MIN  = 2;

endpackage

// File: rtl/blink_modcnt.sv
// Mod-MOD counter with enable and synchronous clear; carry marks the wrapping increment.
module blink_modcnt #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         mck,
    input  logic         rin,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign carry = en & (cnt_q == LAST);

endmodule

// File: rtl/blink_rtc.sv
// Blink RTC: prescaler -> tick/second/minute cascade, latched status with mask/ack,
// and a Z80 I/O read port with a minute/second snapshot taken on TIM0 reads.
module blink_rtc
    import blink_pkg::*;
#(
    parameter int CLK_DIV  = 49152,
    parameter int TICK_MAX = 200,
    parameter int SEC_MAX  = 60,
    parameter int MIN_W    = 21
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       tim_clr,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [7:0] reg_adr,
    input  logic [7:0] reg_wdat,
    output logic [7:0] reg_rdat,
    output logic       rd_hit,
    output logic [2:0] tsta,
    output logic       rtc_int
);

    localparam int PW  = $clog2(CLK_DIV);
    localparam int T0W = $clog2(TICK_MAX);
    localparam int T1W = $clog2(SEC_MAX);

    logic [PW-1:0]    presc_unused;
    logic [T0W-1:0]   tim0;
    logic [T1W-1:0]   tim1;
    logic             tick_ev, sec_ev, min_ev;
    logic [MIN_W-1:0] timm_q, timm_d;
    logic [2:0]       tsta_q, tsta_d, tmk_q, tmk_d, ev, ack;
    logic [T1W-1:0]   snap_tim1_q, snap_tim1_d;
    logic [MIN_W-1:0] snap_timm_q, snap_timm_d;
    logic [23:0]      snap_ext;
    logic [7:0]       rd_data, reg_rdat_q, reg_rdat_d;
    logic             rd_sel, rd_hit_q, rd_hit_d, snap_take;
    logic             wdat_unused;

    assign wdat_unused = &reg_wdat[7:3];

    blink_modcnt #(.MOD(CLK_DIV), .W(PW)) u_presc (
        .mck(mck), .rin(rin), .en(~tim_clr), .clr(tim_clr),
        .value(presc_unused), .carry(tick_ev)
    );

    blink_modcnt #(.MOD(TICK_MAX), .W(T0W)) u_tim0 (
        .mck(mck), .rin(rin), .en(tick_ev), .clr(tim_clr),
        .value(tim0), .carry(sec_ev)
    );

    blink_modcnt #(.MOD(SEC_MAX), .W(T1W)) u_tim1 (
        .mck(mck), .rin(rin), .en(sec_ev), .clr(tim_clr),
        .value(tim1), .carry(min_ev)
    );

    // New events are OR-ed in after the ack mask so a coincident ack never loses one.
    always_comb begin
        ev            = '0;
        ev[TSTA_TICK] = tick_ev;
        ev[TSTA_SEC]  = sec_ev;
        ev[TSTA_MIN]  = min_ev;
        ack           = (reg_wr && reg_adr == RTC_TACK) ? reg_wdat[2:0] : 3'b000;
        tsta_d        = (tsta_q & ~ack) | ev;
        tmk_d         = (reg_wr && reg_adr == RTC_TMK) ? reg_wdat[2:0] : tmk_q;
        timm_d        = tim_clr ? '0 : (min_ev ? timm_q + 1'b1 : timm_q);
        snap_take     = reg_rd && (reg_adr == RTC_TIM0);
        snap_tim1_d   = snap_take ? tim1 : snap_tim1_q;
        snap_timm_d   = snap_take ? timm_q : snap_timm_q;
    end

    assign snap_ext = 24'(snap_timm_q);

    always_comb begin
        rd_sel  = 1'b1;
        rd_data = 8'h00;
        case (reg_adr)
            RTC_TSTA: rd_data = {5'b00000, tsta_q};
            RTC_TIM0: rd_data = 8'(tim0);
            RTC_TIM1: rd_data = 8'(snap_tim1_q);
            RTC_TIM2: rd_data = snap_ext[7:0];
            RTC_TIM3: rd_data = snap_ext[15:8];
            RTC_TIM4: rd_data = snap_ext[23:16];
            default:  rd_sel  = 1'b0;
        endcase
        rd_hit_d   = reg_rd & rd_sel;
        reg_rdat_d = rd_hit_d ? rd_data : reg_rdat_q;
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            timm_q      <= '0;
            tsta_q      <= '0;
            tmk_q       <= '0;
            snap_tim1_q <= '0;
            snap_timm_q <= '0;
            reg_rdat_q  <= '0;
            rd_hit_q    <= 1'b0;
        end else begin
            timm_q      <= timm_d;
            tsta_q      <= tsta_d;
            tmk_q       <= tmk_d;
            snap_tim1_q <= snap_tim1_d;
            snap_timm_q <= snap_timm_d;
            reg_rdat_q  <= reg_rdat_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    assign reg_rdat = reg_rdat_q;
    assign rd_hit   = rd_hit_q;
    assign tsta     = tsta_q;
    assign rtc_int  = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_blink_rtc.sv
// Bench for blink_rtc: two instances (MIN_W=21 and MIN_W=8) driven in lockstep,
// read data checked through an expected-value queue, status/interrupt checked inline.
module tb_blink_rtc;
    import blink_pkg::*;

    localparam int CD = 4;
    localparam int TM = 3;
    localparam int SM = 2;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    logic       mck = 1'b0;
    logic       rin = 1'b1;
    logic       tim_clr = 1'b0;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [7:0] reg_adr = 8'h00;
    logic [7:0] reg_wdat = 8'h00;
    logic [7:0] rdat_a, rdat_b;
    logic       hit_a, hit_b, int_a, int_b;
    logic [2:0] tsta_a, tsta_b;

    int   total = 0;
    int   bad = 0;
    int   run = 0;
    int   snap_t1 = 0;
    int   snap_m = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 mck = ~mck;

    blink_rtc #(.CLK_DIV(CD), .TICK_MAX(TM), .SEC_MAX(SM), .MIN_W(21)) u_a (
        .mck(mck), .rin(rin), .tim_clr(tim_clr), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_adr(reg_adr), .reg_wdat(reg_wdat), .reg_rdat(rdat_a), .rd_hit(hit_a),
        .tsta(tsta_a), .rtc_int(int_a)
    );

    blink_rtc #(.CLK_DIV(CD), .TICK_MAX(TM), .SEC_MAX(SM), .MIN_W(8)) u_b (
        .mck(mck), .rin(rin), .tim_clr(tim_clr), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_adr(reg_adr), .reg_wdat(reg_wdat), .reg_rdat(rdat_b), .rd_hit(hit_b),
        .tsta(tsta_b), .rtc_int(int_b)
    );

    // Cycles of free counting since the last reset or clear.
    always @(posedge mck) run <= (rin || tim_clr) ? 0 : run + 1;

    always @(negedge mck) begin
        if (hit_a || hit_b) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: hit=%b%b rdat a=%h b=%h, want no hit", hit_a, hit_b, rdat_a, rdat_b);
            end else begin
                mon_e = sb.pop_front();
                if (hit_a !== 1'b1 || hit_b !== 1'b1 || rdat_a !== mon_e.a || rdat_b !== mon_e.b) begin
                    bad++;
                    $display("FAIL rd_%h: got hit=%b%b a=%h b=%h, want hit=11 a=%h b=%h",
                             mon_e.adr, hit_a, hit_b, rdat_a, rdat_b, mon_e.a, mon_e.b);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] mdl(input logic [7:0] adr, input int wbits, input int t0);
        int m;
        m = snap_m & ((1 << wbits) - 1);
        case (adr)
            RTC_TIM0: return 8'(t0);
            RTC_TIM1: return 8'(snap_t1);
            RTC_TIM2: return 8'(m & 255);
            RTC_TIM3: return 8'((m >> 8) & 255);
            RTC_TIM4: return 8'((m >> 16) & 255);
            default:  return 8'h00;
        endcase
    endfunction

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge mck);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] adr, input logic [2:0] st_exp);
        exp_t e;
        int   ticks, t0, secs;
        ticks = run / CD;
        t0    = ticks % TM;
        secs  = ticks / TM;
        if (adr == RTC_TIM0) begin
            snap_t1 = secs % SM;
            snap_m  = secs / SM;
        end
        e.adr = adr;
        if (adr == RTC_TSTA) begin
            e.a = {5'b00000, st_exp};
            e.b = e.a;
        end else begin
            e.a = mdl(adr, 21, t0);
            e.b = mdl(adr, 8, t0);
        end
        sb.push_back(e);
        reg_rd  = 1'b1;
        reg_adr = adr;
        cyc();
        reg_rd  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] d);
        reg_wr   = 1'b1;
        reg_adr  = adr;
        reg_wdat = d;
        cyc();
        reg_wr   = 1'b0;
    endtask

    task automatic wait_run(input int target);
        for (int i = 0; i < 8000 && run < target; i++) cyc();
        total++;
        if (run != target) begin
            bad++;
            $display("FAIL wait_run: reached run=%0d, want %0d", run, target);
        end
    endtask

    task automatic drain();
        cyc(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d reads outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reg_rd = 1'b1; reg_adr = RTC_TSTA;
        reg_wr = 1'b1; reg_wdat = 8'h07;
        cyc(3);
        reg_rd = 1'b0; reg_wr = 1'b0;
        total++;
        if (tsta_a !== 3'b000 || tsta_b !== 3'b000 || int_a !== 1'b0 || int_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: tsta=%b/%b int=%b/%b, want 000/000 0/0", tsta_a, tsta_b, int_a, int_b);
        end
        total++;
        if (rdat_a !== 8'h00 || rdat_b !== 8'h00 || hit_a !== 1'b0 || hit_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_read: rdat=%h/%h hit=%b%b, want 00/00 00", rdat_a, rdat_b, hit_a, hit_b);
        end
        rin = 1'b0;
    endtask

    task automatic test_tick();
        cyc(3);
        total++;
        if (tsta_a !== 3'b000) begin
            bad++;
            $display("FAIL pre_tick: tsta=%b, want 000", tsta_a);
        end
        cyc();
        total++;
        if (tsta_a !== 3'b001 || tsta_b !== 3'b001 || int_a !== 1'b0) begin
            bad++;
            $display("FAIL first_tick: tsta=%b/%b int=%b, want 001/001 0", tsta_a, tsta_b, int_a);
        end
        rd(RTC_TIM0, 3'b000);
        total++;
        if (hit_a !== 1'b1) begin
            bad++;
            $display("FAIL rd_latency: hit=%b one cycle after read, want 1", hit_a);
        end
    endtask

    task automatic test_mask();
        wait_run(24);
        total++;
        if (tsta_a !== 3'b111 || tsta_b !== 3'b111) begin
            bad++;
            $display("FAIL first_min: tsta=%b/%b, want 111/111", tsta_a, tsta_b);
        end
        wr(RTC_TMK, 8'h06);
        total++;
        if (int_a !== 1'b1 || int_b !== 1'b1) begin
            bad++;
            $display("FAIL int_masked_on: int=%b/%b, want 1/1", int_a, int_b);
        end
        rd(RTC_TIM0, 3'b000);
        rd(RTC_TIM2, 3'b000);
        wr(RTC_TACK, 8'h06);
        total++;
        if (tsta_a !== 3'b001 || int_a !== 1'b0) begin
            bad++;
            $display("FAIL ack_sec_min: tsta=%b int=%b, want 001 0", tsta_a, int_a);
        end
        rd(RTC_TSTA, 3'b001);
        drain();
    endtask

    task automatic test_ack_race();
        wait_run(32);
        wr(RTC_TACK, 8'h01);
        total++;
        if (tsta_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL ack_tick: tsta[0]=%b, want 0", tsta_a[0]);
        end
        wait_run(35);
        wr(RTC_TACK, 8'h01);
        total++;
        if (tsta_a !== 3'b011 || tsta_b !== 3'b011) begin
            bad++;
            $display("FAIL ack_race: tsta=%b/%b, want 011/011", tsta_a, tsta_b);
        end
    endtask

    task automatic test_wrap();
        wait_run(6125);
        wr(RTC_TACK, 8'h07);
        total++;
        if (tsta_b !== 3'b000) begin
            bad++;
            $display("FAIL pre_wrap_ack: tsta=%b, want 000", tsta_b);
        end
        wait_run(6143);
        rd(RTC_TIM0, 3'b000);
        rd(RTC_TIM2, 3'b000);
        rd(RTC_TIM3, 3'b000);
        total++;
        if (tsta_a !== 3'b111 || tsta_b !== 3'b111) begin
            bad++;
            $display("FAIL wrap_events: tsta=%b/%b, want 111/111", tsta_a, tsta_b);
        end
        rd(RTC_TIM0, 3'b000);
        rd(RTC_TIM1, 3'b000);
        rd(RTC_TIM2, 3'b000);
        rd(RTC_TIM3, 3'b000);
        rd(RTC_TIM4, 3'b000);
        drain();
    endtask

    task automatic test_clr();
        wr(RTC_TMK, 8'h07);
        tim_clr = 1'b1;
        cyc();
        wr(RTC_TACK, 8'h07);
        cyc(8);
        total++;
        if (tsta_a !== 3'b000 || tsta_b !== 3'b000 || int_a !== 1'b0) begin
            bad++;
            $display("FAIL clr_hold: tsta=%b/%b int=%b, want 000/000 0", tsta_a, tsta_b, int_a);
        end
        rd(RTC_TIM0, 3'b000);
        rd(RTC_TIM1, 3'b000);
        rd(RTC_TIM2, 3'b000);
        tim_clr = 1'b0;
        cyc(4);
        total++;
        if (tsta_a !== 3'b001 || int_a !== 1'b1 || int_b !== 1'b1) begin
            bad++;
            $display("FAIL clr_release: tsta=%b int=%b/%b, want 001 1/1", tsta_a, int_a, int_b);
        end
        rd(RTC_TSTA, 3'b001);
        drain();
        rin = 1'b1;
        cyc();
        total++;
        if (tsta_a !== 3'b000 || int_a !== 1'b0 || rdat_a !== 8'h00 || rdat_b !== 8'h00 || hit_a !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: tsta=%b int=%b rdat=%h/%h hit=%b, want 000 0 00/00 0",
                     tsta_a, int_a, rdat_a, rdat_b, hit_a);
        end
        rin = 1'b0;
        snap_t1 = 0;
        snap_m  = 0;
    endtask

    task automatic test_reads();
        wait_run(13);
        rd(RTC_TSTA, 3'b011);
        rd(RTC_TIM1, 3'b000);
        rd(RTC_TIM0, 3'b000);
        rd(RTC_TIM1, 3'b000);
        reg_rd = 1'b1; reg_adr = 8'h42;
        cyc();
        reg_rd = 1'b0;
        total++;
        if (hit_a !== 1'b0 || hit_b !== 1'b0 || rdat_a !== 8'h01) begin
            bad++;
            $display("FAIL rd_unmapped: hit=%b%b rdat=%h, want 00 01", hit_a, hit_b, rdat_a);
        end
        reg_rd = 1'b1; reg_adr = RTC_TACK;
        cyc();
        reg_rd = 1'b0;
        total++;
        if (hit_a !== 1'b0 || rdat_a !== 8'h01) begin
            bad++;
            $display("FAIL rd_tack: hit=%b rdat=%h, want 0 01", hit_a, rdat_a);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_tick();
        test_mask();
        test_ack_race();
        test_wrap();
        test_clr();
        test_reads();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
